// File: rtl/iic_cfg_pkg.sv
// rtl/iic_cfg_pkg.sv - shared types and constants for the IIC register-init sequencer
//
// Purpose: sequencer state encoding, table entry layout, driver mode constants
//          and a saturating increment helper for the retry statistic.
// Ports:   none (package).

package iic_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_CHECK,
    ST_DELAY,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RETRY,
    ST_NEXT,
    ST_END
  } state_e;

  // An entry whose address is DELAY_MARKER is a pause of data*DLY_UNIT clocks
  localparam logic [15:0] DELAY_MARKER = 16'hFFFF;
  localparam logic [1:0]  IIC_MODE_WR  = 2'b00;
  localparam logic [7:0]  IIC_WR_LEN   = 8'd1;

  // Table word layout: {addr[15:0], data[7:0]}
  localparam int ENTRY_W        = 24;
  localparam int ENTRY_ADDR_LSB = 8;
  localparam int ENTRY_DATA_LSB = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iic_cfg_timer.sv
// rtl/iic_cfg_timer.sv - loadable down-counter with expiry flag
//
// Purpose: one counter shared by power-up wait, delay entries and transaction
//          timeout; the sequencer reloads it on entry to each timed state.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   load_i      load load_val_i this cycle
//   load_val_i  cycles to count
//   expired_o   count reached zero (suppressed in the load cycle)

module iic_cfg_timer #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A stale zero from the previous use must not look like expiry while reloading
  assign expired_o = (cnt_q == '0) && !load_i;

endmodule

// File: rtl/iic_cfg_seq.sv
// rtl/iic_cfg_seq.sv - IIC register-initialisation table sequencer
//
// Purpose: walks a ROM of {reg_addr, reg_data} entries, issues one single-byte
//          IIC write per entry, retries NACKed/timed-out entries and reports
//          done/fail status. Address FFFF entries are pauses.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, auto_start                run request pulse / run once after reset
//   tbl_idx, tbl_data                table ROM address / entry (1-cycle latency)
//   iic_exec, iic_addr, iic_wdata    request to the byte driver
//   iic_mode, iic_rw_len             constant write mode, length 1
//   iic_idle, iic_done, iic_err_flag driver status
//   busy, cfg_done, cfg_fail         run status
//   fail_idx, retry_total            failing entry, retries in last run

module iic_cfg_seq
  import iic_cfg_pkg::*;
#(
  parameter int TABLE_LEN    = 32,
  parameter int IDX_W        = 6,
  parameter int MAX_RETRY    = 3,
  parameter int TO_CYCLES    = 65535,
  parameter int PWRUP_CYCLES = 100000,
  parameter int DLY_UNIT     = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               auto_start,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [ENTRY_W-1:0] tbl_data,
  output logic               iic_exec,
  output logic [15:0]        iic_addr,
  output logic [7:0]         iic_wdata,
  output logic [1:0]         iic_mode,
  output logic [7:0]         iic_rw_len,
  input  logic               iic_idle,
  input  logic               iic_done,
  input  logic               iic_err_flag,
  output logic               busy,
  output logic               cfg_done,
  output logic               cfg_fail,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [7:0]         retry_total
);

  localparam int DLY_MAX   = 255 * DLY_UNIT;
  localparam int TMR_MAX_A = (PWRUP_CYCLES > TO_CYCLES) ? PWRUP_CYCLES : TO_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > DLY_MAX) ? TMR_MAX_A : DLY_MAX;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int ATT_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TABLE_LEN - 1);
  localparam logic [ATT_W-1:0] MAX_RETRY_C = ATT_W'(MAX_RETRY);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ATT_W-1:0]   attempts_q;
  entry_t             entry_q;
  logic               fetch_wait_q;
  logic               err_seen_q;
  logic               iic_exec_q;
  logic [15:0]        iic_addr_q;
  logic [7:0]         iic_wdata_q;
  logic               busy_q;
  logic               cfg_done_q;
  logic               cfg_fail_q;
  logic [IDX_W-1:0]   fail_idx_q;
  logic [7:0]         retry_total_q;
  logic               tmr_load_q;
  logic [TMR_W-1:0]   tmr_val_q;
  logic               tmr_expired;
  logic [TMR_W-1:0]   dly_cycles;

  assign dly_cycles = TMR_W'(entry_q.data) * TMR_W'(DLY_UNIT);

  iic_cfg_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load_q),
    .load_val_i (tmr_val_q),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= auto_start ? ST_PWRUP : ST_IDLE;
      idx_q         <= '0;
      attempts_q    <= '0;
      entry_q       <= '0;
      fetch_wait_q  <= 1'b0;
      err_seen_q    <= 1'b0;
      iic_exec_q    <= 1'b0;
      iic_addr_q    <= '0;
      iic_wdata_q   <= '0;
      busy_q        <= 1'b0;
      cfg_done_q    <= 1'b0;
      cfg_fail_q    <= 1'b0;
      fail_idx_q    <= '0;
      retry_total_q <= '0;
      // Arm the power-up wait so it starts counting on the first free cycle
      tmr_load_q    <= 1'b1;
      tmr_val_q     <= TMR_W'(PWRUP_CYCLES);
    end else begin
      tmr_load_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_PWRUP: begin
          if ((state_q == ST_IDLE && start) || (state_q == ST_PWRUP && tmr_expired)) begin
            idx_q         <= '0;
            attempts_q    <= '0;
            cfg_done_q    <= 1'b0;
            cfg_fail_q    <= 1'b0;
            retry_total_q <= '0;
            busy_q        <= 1'b1;
            fetch_wait_q  <= 1'b1;
            state_q       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // First cycle presents tbl_idx; ROM data is valid on the second
          if (fetch_wait_q) begin
            fetch_wait_q <= 1'b0;
          end else begin
            entry_q.addr <= tbl_data[ENTRY_ADDR_LSB +: 16];
            entry_q.data <= tbl_data[ENTRY_DATA_LSB +: 8];
            state_q      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (entry_q.addr == DELAY_MARKER) begin
            if (entry_q.data == 8'd0) begin
              state_q <= ST_NEXT;
            end else begin
              tmr_load_q <= 1'b1;
              tmr_val_q  <= dly_cycles;
              state_q    <= ST_DELAY;
            end
          end else if (iic_idle) begin
            // Driver may still be finishing a frame from before a reset
            iic_exec_q  <= 1'b1;
            iic_addr_q  <= entry_q.addr;
            iic_wdata_q <= entry_q.data;
            err_seen_q  <= 1'b0;
            tmr_load_q  <= 1'b1;
            tmr_val_q   <= TMR_W'(TO_CYCLES);
            state_q     <= ST_ISSUE;
          end
        end
        ST_DELAY: begin
          if (tmr_expired) state_q <= ST_NEXT;
        end
        ST_ISSUE: begin
          // Hold exec until the slow-clocked driver shows it has taken it
          if (!iic_idle) begin
            iic_exec_q <= 1'b0;
            state_q    <= ST_WAIT_DONE;
          end else if (tmr_expired) begin
            iic_exec_q <= 1'b0;
            state_q    <= ST_RETRY;
          end
        end
        ST_WAIT_DONE: begin
          err_seen_q <= err_seen_q | iic_err_flag;
          if (iic_done) begin
            state_q <= (err_seen_q || iic_err_flag) ? ST_RETRY : ST_NEXT;
          end else if (tmr_expired) begin
            state_q <= ST_RETRY;
          end
        end
        ST_RETRY: begin
          if (attempts_q < MAX_RETRY_C) begin
            attempts_q    <= attempts_q + 1'b1;
            retry_total_q <= sat_inc8(retry_total_q);
            state_q       <= ST_CHECK;
          end else begin
            fail_idx_q <= idx_q;
            cfg_fail_q <= 1'b1;
            state_q    <= ST_END;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            cfg_done_q <= 1'b1;
            state_q    <= ST_END;
          end else begin
            idx_q        <= idx_q + 1'b1;
            attempts_q   <= '0;
            fetch_wait_q <= 1'b1;
            state_q      <= ST_FETCH;
          end
        end
        ST_END: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tbl_idx     = idx_q;
  assign iic_exec    = iic_exec_q;
  assign iic_addr    = iic_addr_q;
  assign iic_wdata   = iic_wdata_q;
  assign iic_mode    = IIC_MODE_WR;
  assign iic_rw_len  = IIC_WR_LEN;
  assign busy        = busy_q;
  assign cfg_done    = cfg_done_q;
  assign cfg_fail    = cfg_fail_q;
  assign fail_idx    = fail_idx_q;
  assign retry_total = retry_total_q;

endmodule
